// File: rtl/microwave_cook_controller.sv
// Microwave top-level sequencer: mode enables for the keyboard converter,
// BCD MM:SS cook countdown on a 1 s prescaler, door-gated magnetron and
// a timed completion beep.
module microwave_cook_controller #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned BEEP_SECS     = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic        door_open,
  input  logic        mode_auto,
  input  logic        enter,
  input  logic [15:0] duration_in,
  input  logic        auto_set,
  input  logic [2:0]  auto_mode,
  output logic        check_load,
  output logic        check_duration,
  output logic        select_auto,
  output logic        magnetron_on,
  output logic [15:0] time_left,
  output logic [2:0]  state_out,
  output logic        beep
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_SECS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INPUT   = 3'd1,
    S_PROC_IN = 3'd2,
    S_READY   = 3'd3,
    S_COOK    = 3'd4,
    S_PAUSE   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          chk_q, sel_q, mag_q, beep_q;

  logic          tick;
  logic          dur_ok;
  logic [15:0]   time_dec;

  // One-second BCD decrement: S0 borrows from S1, 00 seconds wrap to 59
  // and borrow a minute, M0 borrows from M1.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Preset cook times for the auto programs.
  function automatic logic [15:0] auto_time(input logic [2:0] code);
    logic [15:0] t;
    case (code)
      3'd0:    t = 16'h0230;
      3'd1:    t = 16'h0500;
      3'd2:    t = 16'h0800;
      3'd3:    t = 16'h0400;
      3'd4:    t = 16'h0130;
      3'd5:    t = 16'h0200;
      3'd6:    t = 16'h1000;
      default: t = 16'h0300;
    endcase
    return t;
  endfunction

  assign tick     = (presc_q == PRE_MAX);
  assign time_dec = bcd_dec(time_q);
  assign dur_ok   = (duration_in[15:12] <= 4'd9) && (duration_in[11:8] <= 4'd9) &&
                    (duration_in[7:4]   <= 4'd5) && (duration_in[3:0]  <= 4'd9) &&
                    (duration_in != 16'h0000);

  // Next-state, countdown and prescaler logic; cancel > door > keys > tick.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!cancel && start) state_d = mode_auto ? S_PROC_IN : S_INPUT;
      end
      S_INPUT: begin
        if (cancel) state_d = S_IDLE;
        else if (enter && dur_ok) begin
          time_d  = duration_in;
          state_d = S_READY;
        end
      end
      S_PROC_IN: begin
        if (cancel) state_d = S_IDLE;
        else if (auto_set) begin
          time_d  = auto_time(auto_mode);
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (cancel) state_d = S_IDLE;
        else if (start && !door_open) begin
          presc_d = '0;
          state_d = S_COOK;
        end
      end
      S_COOK: begin
        // Pausing freezes the prescaler so the fractional second survives.
        if (cancel || door_open) state_d = S_PAUSE;
        else if (tick) begin
          presc_d = '0;
          time_d  = time_dec;
          if (time_dec == 16'h0000) begin
            bcnt_d  = '0;
            state_d = S_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (cancel) state_d = S_IDLE;
        else if (start && !door_open) state_d = S_COOK;
      end
      S_DONE: begin
        if (cancel || start) state_d = S_IDLE;
        else if (tick) begin
          presc_d = '0;
          if (bcnt_q == BEEP_MAX) state_d = S_IDLE;
          else bcnt_d = bcnt_q + BW'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // IDLE always shows a cleared display and idle counters.
    if (state_d == S_IDLE) begin
      time_d  = '0;
      presc_d = '0;
      bcnt_d  = '0;
    end
  end

  // State, datapath and registered output decode of the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      chk_q   <= 1'b0;
      sel_q   <= 1'b0;
      mag_q   <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      chk_q   <= (state_d == S_INPUT);
      sel_q   <= (state_d == S_PROC_IN);
      mag_q   <= (state_d == S_COOK);
      beep_q  <= (state_d == S_DONE);
    end
  end

  assign check_load     = chk_q;
  assign check_duration = chk_q;
  assign select_auto    = sel_q;
  assign magnetron_on   = mag_q;
  assign beep           = beep_q;
  assign time_left      = time_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Bench for microwave_cook_controller: directed scenarios plus random
// stimulus, all checked every cycle against a seconds-based model.
module tb_microwave_cook_controller;

  localparam int TPS  = 4;
  localparam int BSEC = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, cancel = 1'b0, door_open = 1'b0, mode_auto = 1'b0;
  logic        enter = 1'b0, auto_set = 1'b0;
  logic [15:0] duration_in = 16'h0;
  logic [2:0]  auto_mode = 3'd0;
  logic        check_load, check_duration, select_auto, magnetron_on, beep;
  logic [15:0] time_left;
  logic [2:0]  state_out;

  int total = 0;
  int bad   = 0;

  microwave_cook_controller #(.TICKS_PER_SEC(TPS), .BEEP_SECS(BSEC)) dut (
    .clock(clock), .resetn(resetn), .start(start), .cancel(cancel),
    .door_open(door_open), .mode_auto(mode_auto), .enter(enter),
    .duration_in(duration_in), .auto_set(auto_set), .auto_mode(auto_mode),
    .check_load(check_load), .check_duration(check_duration),
    .select_auto(select_auto), .magnetron_on(magnetron_on),
    .time_left(time_left), .state_out(state_out), .beep(beep)
  );

  always #5 clock = ~clock;

  // Model: state number, remaining seconds, cycle position within the
  // current second while cooking, cycles spent beeping.
  int m_st = 0, m_secs = 0, m_pre = 0, m_dc = 0;
  int auto_secs[8] = '{150, 300, 480, 240, 90, 120, 600, 180};

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("state", 32'(state_out), 32'(m_st));
    chk("time_left", 32'(time_left), 32'(to_bcd(m_secs)));
    chk("check_load", 32'(check_load), 32'(m_st == 1));
    chk("check_duration", 32'(check_duration), 32'(m_st == 1));
    chk("select_auto", 32'(select_auto), 32'(m_st == 2));
    chk("magnetron_on", 32'(magnetron_on), 32'(m_st == 4));
    chk("beep", 32'(beep), 32'(m_st == 6));
  endtask

  task automatic model_reset();
    m_st = 0; m_secs = 0; m_pre = 0; m_dc = 0;
  endtask

  task automatic model_step(input bit st, input bit ca, input bit en, input bit au,
                            input bit dr, input bit ma, input logic [15:0] dur,
                            input logic [2:0] am);
    int nst, d3, d2, d1, d0;
    nst = m_st;
    d3 = int'(dur[15:12]); d2 = int'(dur[11:8]); d1 = int'(dur[7:4]); d0 = int'(dur[3:0]);
    case (m_st)
      0: if (!ca && st) nst = ma ? 2 : 1;
      1: if (ca) nst = 0;
         else if (en && d3 <= 9 && d2 <= 9 && d1 <= 5 && d0 <= 9 && dur != 0) begin
           m_secs = (d3 * 10 + d2) * 60 + d1 * 10 + d0;
           nst = 3;
         end
      2: if (ca) nst = 0;
         else if (au) begin m_secs = auto_secs[am]; nst = 3; end
      3: if (ca) nst = 0;
         else if (st && !dr) begin m_pre = 0; nst = 4; end
      4: if (ca || dr) nst = 5;
         else if (m_pre == TPS - 1) begin
           m_pre = 0;
           m_secs--;
           if (m_secs == 0) begin nst = 6; m_dc = 0; end
         end else m_pre++;
      5: if (ca) nst = 0;
         else if (st && !dr) nst = 4;
      6: if (ca || st) nst = 0;
         else if (m_dc == BSEC * TPS - 1) nst = 0;
         else m_dc++;
      default: nst = 0;
    endcase
    if (nst == 0) begin m_secs = 0; m_pre = 0; end
    m_st = nst;
  endtask

  // Drive one cycle of inputs at a falling edge, clock it, check at the next.
  task automatic cyc(input bit st, input bit ca, input bit en, input bit au,
                     input bit dr, input bit ma, input logic [15:0] dur,
                     input logic [2:0] am);
    start = st; cancel = ca; enter = en; auto_set = au;
    door_open = dr; mode_auto = ma; duration_in = dur; auto_mode = am;
    model_step(st, ca, en, au, dr, ma, dur, am);
    @(negedge clock);
    start = 1'b0; cancel = 1'b0; enter = 1'b0; auto_set = 1'b0;
    chk_all();
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, dr, 0, 16'h0, 3'd0);
  endtask

  // Enter a manual time and start cooking.
  task automatic manual_go(input logic [15:0] dur);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 3'd0);
    cyc(0, 0, 1, 0, 0, 0, dur, 3'd0);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 3'd0);
  endtask

  initial begin
    bit dr;
    bit st, ca, en, au, ma;
    logic [15:0] dur;
    logic [2:0] am;
    int r;

    #12;
    chk_all();                       // during reset
    @(negedge clock);
    resetn = 1'b1;
    chk_all();

    // Manual cook of 3 s.
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 3'd0);
    chk("man_input", 32'(state_out), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 16'h0003, 3'd0);
    chk("man_ready_tl", 32'(time_left), 32'h0003);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 3'd0);
    chk("man_cook", 32'(state_out), 32'd4);
    idle(4, 0);  chk("man_t4", 32'(time_left), 32'h0002);
    idle(4, 0);  chk("man_t8", 32'(time_left), 32'h0001);
    idle(4, 0);  chk("man_done", 32'(state_out), 32'd6);
    chk("man_mag_off", 32'(magnetron_on), 32'd0);
    idle(11, 0); chk("man_beep11", 32'(beep), 32'd1);
    idle(1, 0);  chk("man_idle", 32'(state_out), 32'd0);
    chk("man_beep_off", 32'(beep), 32'd0);

    // Minute borrows.
    manual_go(16'h0100);
    idle(4, 0); chk("borrow_0059", 32'(time_left), 32'h0059);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);
    manual_go(16'h1000);
    idle(4, 0); chk("borrow_0959", 32'(time_left), 32'h0959);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);

    // Invalid entries are rejected.
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 3'd0);
    cyc(0, 0, 1, 0, 0, 0, 16'h0075, 3'd0); chk("inv_0075", 32'(state_out), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 16'h0000, 3'd0); chk("inv_0000", 32'(state_out), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 16'h00A1, 3'd0); chk("inv_00A1", 32'(state_out), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 16'h0010, 3'd0); chk("inv_then_ok", 32'(state_out), 32'd3);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);

    // Auto program 6.
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 3'd0);
    chk("auto_sel", 32'(select_auto), 32'd1);
    cyc(0, 0, 0, 1, 0, 1, 16'h0, 3'd6);
    chk("auto_tl", 32'(time_left), 32'h1000);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);

    // Door opened on a tick cycle, then resume with the partial second.
    manual_go(16'h0005);
    idle(3, 0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0, 3'd0);
    chk("door_pause", 32'(state_out), 32'd5);
    chk("door_no_dec", 32'(time_left), 32'h0005);
    cyc(1, 0, 0, 0, 1, 0, 16'h0, 3'd0);
    chk("door_start_ign", 32'(state_out), 32'd5);
    idle(1, 0);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 3'd0);
    idle(1, 0);
    chk("door_resume_tick", 32'(time_left), 32'h0004);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 3'd0);

    // Asynchronous reset in the middle of a cook.
    manual_go(16'h0042);
    idle(2, 0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_async_state", 32'(state_out), 32'd0);
    chk_all();
    @(negedge clock);
    chk_all();
    resetn = 1'b1;
    idle(3, 0);
    chk("rst_stays_idle", 32'(state_out), 32'd0);

    // Random traffic.
    dr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 3) dr = ~dr;
      st = ($urandom_range(99) < 8);
      ca = ($urandom_range(99) < 2);
      en = ($urandom_range(99) < 20);
      au = ($urandom_range(99) < 15);
      ma = 1'($urandom_range(1));
      am = 3'($urandom_range(7));
      r  = $urandom_range(3);
      if (r == 0)      dur = 16'($urandom);
      else if (r == 1) dur = ($urandom_range(1) != 0) ? 16'h0100 : 16'h0012;
      else             dur = {8'h00, 4'($urandom_range(1)), 4'($urandom_range(9))};
      // Keys with the door open only where the door's effect is defined.
      if (dr && !(m_st == 3 || m_st == 4 || m_st == 5)) begin
        st = 1'b0; en = 1'b0; au = 1'b0;
      end
      cyc(st, ca, en, au, dr, ma, dur, am);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
